// File: rtl/dcs_pkg.sv
// Shared definitions for the DCS slow-control UDP path: header size, FSM
// states and default framer parameters.
package dcs_pkg;

   localparam int unsigned UDP_HDR_LEN          = 8;
   localparam logic [15:0] SLOWCONTROL_PORT_DEF = 16'h1001;
   localparam int unsigned MAX_LEN_DEF          = 1024;
   localparam int unsigned IFG_CYCLES_DEF       = 12;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ACK,
      HDR,
      PAY,
      GAP
   } tx_state_t;

endpackage

// File: rtl/dcs_udp_txfmt_if.sv
// Reply-request side and MAC transmit side of the DCS UDP framer, bundled
// so the framer (master) and its environment (slave) share one port.
interface dcs_udp_txfmt_if;

   logic        dcs_tx_req;
   logic [10:0] dcs_tx_len;
   logic [15:0] dcs_tx_dst_port;
   logic        dcs_tx_rd;
   logic [7:0]  dcs_tx_data;
   logic        dcs_tx_busy;
   logic        dcs_tx_done;
   logic        dcs_tx_err;
   logic [7:0]  udp_txd;
   logic        udp_tx_dv;
   logic        udp_tx_ack;

   modport master (
      input  dcs_tx_req, dcs_tx_len, dcs_tx_dst_port, dcs_tx_data, udp_tx_ack,
      output dcs_tx_rd, dcs_tx_busy, dcs_tx_done, dcs_tx_err, udp_txd, udp_tx_dv
   );

   modport slave (
      output dcs_tx_req, dcs_tx_len, dcs_tx_dst_port, dcs_tx_data, udp_tx_ack,
      input  dcs_tx_rd, dcs_tx_busy, dcs_tx_done, dcs_tx_err, udp_txd, udp_tx_dv
   );

endinterface

// File: rtl/dcs_udp_txfmt.sv
// UDP transmit framer: prepends an 8-byte UDP header to a DCS reply payload
// and streams the frame byte-wide to the MAC, then enforces an idle gap.
module dcs_udp_txfmt
   import dcs_pkg::*;
#(
   parameter logic [15:0] slowcontrol_port = SLOWCONTROL_PORT_DEF,
   parameter int unsigned MAX_LEN          = MAX_LEN_DEF,
   parameter int unsigned IFG_CYCLES       = IFG_CYCLES_DEF
) (
   input  logic            udp_tx_clk,
   input  logic            reset_n,
   dcs_udp_txfmt_if.master bus
);

   tx_state_t   state;
   logic [10:0] cnt;
   logic [10:0] len_q;
   logic [15:0] dst_q;
   logic [15:0] udp_len_q;
   logic [7:0]  txd;
   logic        dv;
   logic        rd;
   logic        busy;
   logic        done;
   logic        err;

   logic        len_ok;
   logic        rd_next;
   logic [7:0]  hdr_byte;

   assign len_ok = (bus.dcs_tx_len != 11'd0) && (32'(bus.dcs_tx_len) <= MAX_LEN);

   // Reads run three cycles ahead of the byte on the bus (source latency plus
   // output register), so the strobe starts at header count 2 and stops when
   // three bytes remain to be presented.
   always_comb begin
      rd_next = 1'b0;
      case (state)
         HDR:     rd_next = (cnt <= 11'd2) && (({1'b0, cnt} + {1'b0, len_q}) >= 12'd3);
         PAY:     rd_next = (cnt >= 11'd3);
         default: rd_next = 1'b0;
      endcase
   end

   // Next header byte while in HDR; byte index is 8 - cnt.
   always_comb begin
      hdr_byte = 8'h00;
      case (cnt)
         11'd6:   hdr_byte = dst_q[15:8];
         11'd5:   hdr_byte = dst_q[7:0];
         11'd4:   hdr_byte = udp_len_q[15:8];
         11'd3:   hdr_byte = udp_len_q[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge udp_tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= 11'd0;
         len_q     <= 11'd0;
         dst_q     <= 16'h0000;
         udp_len_q <= 16'h0000;
         txd       <= 8'h00;
         dv        <= 1'b0;
         rd        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         rd   <= rd_next;
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.dcs_tx_req) begin
                  if (len_ok) begin
                     len_q     <= bus.dcs_tx_len;
                     dst_q     <= bus.dcs_tx_dst_port;
                     udp_len_q <= 16'(bus.dcs_tx_len) + 16'(UDP_HDR_LEN);
                     busy      <= 1'b1;
                     dv        <= 1'b1;
                     txd       <= slowcontrol_port[15:8];
                     state     <= WAIT_ACK;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            WAIT_ACK: begin
               if (bus.udp_tx_ack) begin
                  txd   <= slowcontrol_port[7:0];
                  cnt   <= 11'd6;
                  state <= HDR;
               end
            end
            HDR: begin
               if (cnt == 11'd0) begin
                  txd   <= bus.dcs_tx_data;
                  cnt   <= len_q - 11'd1;
                  done  <= (len_q == 11'd1);
                  state <= PAY;
               end else begin
                  txd <= hdr_byte;
                  cnt <= cnt - 11'd1;
               end
            end
            PAY: begin
               if (cnt == 11'd0) begin
                  txd   <= 8'h00;
                  dv    <= 1'b0;
                  cnt   <= 11'(IFG_CYCLES - 1);
                  state <= GAP;
               end else begin
                  txd  <= bus.dcs_tx_data;
                  cnt  <= cnt - 11'd1;
                  done <= (cnt == 11'd1);
               end
            end
            GAP: begin
               if (cnt == 11'd0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 11'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.udp_txd     = txd;
   assign bus.udp_tx_dv   = dv;
   assign bus.dcs_tx_rd   = rd;
   assign bus.dcs_tx_busy = busy;
   assign bus.dcs_tx_done = done;
   assign bus.dcs_tx_err  = err;

endmodule

// File: doc/dcs_udp_txfmt.md
# dcs_udp_txfmt

UDP transmit framer for slow-control (DCS) replies. It takes a payload byte stream from the DCS reply logic and builds an 8-byte UDP header in front of it: source port, destination port, length, and a zero checksum. The framed packet is serialised byte-wide to the client MAC transmit port. It is the transmit counterpart of the DCS command receiver on the same UDP link, and it replies to the source port that receiver captured.

## Interface
Parameters:
- slowcontrol_port, 16'h1001, UDP source port placed in every reply header.
- MAX_LEN, 1024, largest accepted payload length in bytes.
- IFG_CYCLES, 12, idle cycles enforced after each packet before the next request is accepted.

Ports:
- udp_tx_clk  in  1  transmit clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- dcs_tx_req  in  1  single-cycle request to send a reply; sampled only while dcs_tx_busy=0.
- dcs_tx_len  in  11  payload length in bytes; valid with dcs_tx_req.
- dcs_tx_dst_port  in  16  destination port (the captured rx source port); valid with dcs_tx_req.
- dcs_tx_rd  out  1  payload read strobe.
- dcs_tx_data  in  8  payload byte; valid the cycle after dcs_tx_rd.
- dcs_tx_busy  out  1  high from request acceptance to the end of the inter-frame gap.
- dcs_tx_done  out  1  one-cycle pulse when the last payload byte is presented.
- dcs_tx_err  out  1  one-cycle pulse when a request is dropped because its length is illegal.
- udp_txd  out  8  byte to the MAC.
- udp_tx_dv  out  1  frame valid to the MAC.
- udp_tx_ack  in  1  one-cycle MAC acceptance of the first byte.

## Operation
- States: IDLE, WAIT_ACK, HDR, PAY, GAP.
- IDLE:
  - On dcs_tx_req with 1 ≤ dcs_tx_len ≤ MAX_LEN: latch the length and the destination port, compute udp_len = dcs_tx_len + 8 (16-bit, zero-extended), set busy, go to WAIT_ACK.
  - On dcs_tx_req with length 0 or > MAX_LEN: pulse dcs_tx_err, stay in IDLE, busy stays 0.
- WAIT_ACK:
  - Drive udp_tx_dv=1 and udp_txd = slowcontrol_port[15:8].
  - Hold both until udp_tx_ack, then go to HDR.
  - There is no timeout.
- HDR: header bytes 1..7, one per cycle: src[7:0], dst[15:8], dst[7:0], udp_len[15:8], udp_len[7:0], 8'h00, 8'h00.
- PAY:
  - The dcs_tx_len payload bytes are presented back-to-back.
  - The byte counter counts down to 0; the last byte pulses dcs_tx_done.
  - Then drop udp_tx_dv and go to GAP.
- GAP:
  - The counter loads IFG_CYCLES-1 and counts to 0.
  - Then busy drops and the state returns to IDLE.
- dcs_tx_req while busy is ignored; it is not queued.
- The payload source guarantees data on every rd. The framer does no underrun detection.
- Header byte index and payload count share one 11-bit down-counter.

## Timing
- Reset (async assert, sync release): state=IDLE. All of udp_txd, udp_tx_dv, dcs_tx_rd, dcs_tx_busy, dcs_tx_done and dcs_tx_err are 0. Latched length and port are 0.
- Reset mid-frame: udp_tx_dv drops immediately and the frame is truncated. No done pulse is issued.
- Request at cycle R: busy=1 and udp_tx_dv=1 with byte0 from R+1.
- Ack at cycle A (byte0 on the bus): byte k (1..7) at A+k; payload byte i at A+8+i.
- dcs_tx_rd is high for exactly dcs_tx_len consecutive cycles, A+6 .. A+5+len. This covers the 1-cycle source latency plus the output register.
- Last byte at A+7+len, together with dcs_tx_done. udp_tx_dv=0 from A+8+len.
- busy falls at A+8+len+IFG_CYCLES. A new request is accepted in that same cycle.
- udp_tx_ack in the same cycle as the first dv cycle (R+1) is valid.
- udp_tx_ack outside WAIT_ACK is ignored.
- All outputs are registered.

## Structure
- Shared package dcs_pkg holds:
  - UDP_HDR_LEN=8.
  - The state enum (IDLE, WAIT_ACK, HDR, PAY, GAP).
  - The default slowcontrol port 16'h1001.
  - The default MAX_LEN.
- Single module with no sub-module. The header byte mux is a case on the counter inside the module.

## Test plan
- len=4, dst=16'h1777, ack 3 cycles after dv rises, payload DE AD BE EF -> bytes 10 01 17 77 00 0C 00 00 DE AD BE EF; done on EF; rd high 4 cycles starting ack+6.
- len=1, ack in the first dv cycle -> 9-byte frame, udp_len 00 09; busy falls 12 cycles after dv falls.
- len=0, then len=1025 -> dcs_tx_err pulse each time; no dv, no rd, busy stays 0.
- Second request during PAY and during GAP -> ignored. Request in the cycle busy falls -> accepted, next frame starts the following cycle.
- reset_n asserted at payload byte 2 of 8 -> dv, rd and busy go 0 asynchronously. After release, a fresh len=2 request produces a correct 10-byte frame.
- len=MAX_LEN (1024), incrementing payload -> udp_len 04 08; 1032 contiguous dv cycles after ack; payload matches and there is no gap inside the frame.
